// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: sequential fetch issuer with an in-order, address-tagged instruction FIFO.
// Define FETCHQ_BYPASS_EN to forward an accepted return straight to the head when the FIFO is empty.
module imem_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [0:7]  Redirect_Addr,
    input  logic        Deq,
    output logic        Instr_Valid,
    output logic [0:31] Instruction,
    output logic [0:7]  Instr_PC,
    output logic        Mem_Req,
    output logic [0:7]  Mem_Addr,
    input  logic [0:31] Mem_Rdata,
    input  logic        Mem_Rvalid,
    output logic        Proto_Err
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]       fetch_pc, ret_pc;
    logic [CNT_W-1:0] count, outstanding, drop_cnt;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [31:0]      data_q [DEPTH];
    logic [7:0]       tag_q [DEPTH];
    logic [CNT_W:0]   credits;
    logic             rv, accept, head_ok, byp, deq_ok, pop, enq;

    assign credits  = {1'b0, count} + {1'b0, outstanding};
    assign Mem_Req  = !Reset && !Redirect && credits < (CNT_W+1)'(DEPTH);
    assign Mem_Addr = fetch_pc;
    assign rv       = Mem_Rvalid && outstanding != '0;
    assign accept   = rv && drop_cnt == '0 && !Redirect;
    assign head_ok  = count != '0;

`ifdef FETCHQ_BYPASS_EN
    assign byp         = accept && !head_ok;
    assign Instr_Valid = head_ok || byp;
    assign Instruction = head_ok ? data_q[rd_ptr] : byp ? Mem_Rdata : '0;
    assign Instr_PC    = head_ok ? tag_q[rd_ptr] : byp ? ret_pc : '0;
`else
    assign byp         = 1'b0;
    assign Instr_Valid = head_ok;
    assign Instruction = head_ok ? data_q[rd_ptr] : '0;
    assign Instr_PC    = head_ok ? tag_q[rd_ptr] : '0;
`endif

    assign deq_ok = Deq && Instr_Valid && !Redirect;
    assign pop    = deq_ok && head_ok;
    assign enq    = accept && !(byp && Deq);

    always_ff @(posedge Clock) begin
        if (enq) begin
            data_q[wr_ptr] <= Mem_Rdata;
            tag_q[wr_ptr]  <= ret_pc;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_pc    <= '0;
            ret_pc      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            Proto_Err   <= 1'b0;
        end else begin
            if (Mem_Rvalid && outstanding == '0)
                Proto_Err <= 1'b1;
            if (Redirect) begin
                fetch_pc    <= Redirect_Addr;
                ret_pc      <= Redirect_Addr;
                count       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                outstanding <= outstanding - CNT_W'(rv);
                // every return still in flight is stale now, including ones already marked for drop
                drop_cnt    <= outstanding - CNT_W'(rv);
            end else begin
                if (Mem_Req)
                    fetch_pc <= fetch_pc + 8'd1;
                outstanding <= outstanding + CNT_W'(Mem_Req) - CNT_W'(rv);
                if (rv && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CNT_W'(1);
                if (accept)
                    ret_pc <= ret_pc + 8'd1;
                if (enq)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CNT_W'(enq) - CNT_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_queue.sv
// tb_imem_fetch_queue: scoreboard bench with a latency-programmable in-order memory model.
// Expected head entries are queued when the memory returns them and popped on dequeue.
module tb_imem_fetch_queue;
    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Redirect = 1'b0;
    logic [0:7]  Redirect_Addr = '0;
    logic        Deq = 1'b0;
    logic        Instr_Valid;
    logic [0:31] Instruction;
    logic [0:7]  Instr_PC;
    logic        Mem_Req;
    logic [0:7]  Mem_Addr;
    logic [0:31] Mem_Rdata = '0;
    logic        Mem_Rvalid = 1'b0;
    logic        Proto_Err;

    imem_fetch_queue #(.DEPTH(DEPTH), .CNT_W(3)) dut (
        .Clock(Clock), .Reset(Reset), .Redirect(Redirect), .Redirect_Addr(Redirect_Addr),
        .Deq(Deq), .Instr_Valid(Instr_Valid), .Instruction(Instruction), .Instr_PC(Instr_PC),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Rdata(Mem_Rdata), .Mem_Rvalid(Mem_Rvalid),
        .Proto_Err(Proto_Err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] addr;
        int         due;
    } req_t;

    req_t        pend[$];
    logic [39:0] sb[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, stale_n = 0, lat = 1, n_req = 0;
    logic [7:0]  exp_addr = '0;
    logic        exp_perr = 1'b0, rogue = 1'b0, override_en = 1'b0;
    logic [31:0] override_data = '0;
    logic        last_req, last_iv;
    logic [7:0]  last_addr, last_pc;
    logic [31:0] last_ins;

    // One clock cycle: drive memory, check every output against the model, then advance.
    task automatic tick();
        logic        cur_mem, cur_stale, rogue_now, exp_valid, exp_req;
        logic [39:0] e;
        int          sb_before, in_use;
        cur_mem = 1'b0; cur_stale = 1'b0; rogue_now = 1'b0; e = '0;
        Mem_Rvalid = 1'b0;
        Mem_Rdata  = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            cur_mem    = 1'b1;
            Mem_Rvalid = 1'b1;
            Mem_Rdata  = override_en ? override_data : 32'hA000_0000 + 32'(pend[0].addr);
            override_en = 1'b0;
            if (stale_n > 0) begin
                cur_stale = 1'b1;
                stale_n--;
            end
            e = {Mem_Rdata, pend[0].addr};
            void'(pend.pop_front());
        end else if (rogue) begin
            rogue_now  = 1'b1;
            Mem_Rvalid = 1'b1;
            Mem_Rdata  = 32'hDEAD_BEEF;
        end
        rogue = 1'b0;
        sb_before = sb.size();
        in_use = sb_before + pend.size() + (cur_mem ? 1 : 0);
        @(negedge Clock);
        exp_req = !Redirect && in_use < DEPTH;
        checks++;
        if (Mem_Req !== exp_req) begin
            failures++;
            $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, Mem_Req, exp_req);
        end
        if (Mem_Req) begin
            checks++;
            if (Mem_Addr !== exp_addr) begin
                failures++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, Mem_Addr, exp_addr);
            end
            pend.push_back('{addr: exp_addr, due: cyc + lat});
            exp_addr++;
            n_req++;
        end
        if (cur_mem && !cur_stale && !Redirect)
            sb.push_back(e);
`ifdef FETCHQ_BYPASS_EN
        exp_valid = sb.size() != 0;
`else
        exp_valid = sb_before != 0;
`endif
        checks++;
        if (Instr_Valid !== exp_valid) begin
            failures++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, Instr_Valid, exp_valid);
        end
        if (Instr_Valid && exp_valid) begin
            checks++;
            if ({Instruction, Instr_PC} !== sb[0]) begin
                failures++;
                $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, Instruction, Instr_PC,
                         sb[0][39:8], sb[0][7:0]);
            end
            if (Deq && !Redirect)
                void'(sb.pop_front());
        end
        checks++;
        if (Proto_Err !== exp_perr) begin
            failures++;
            $display("FAIL proto_err cyc=%0d got=%b exp=%b", cyc, Proto_Err, exp_perr);
        end
        if (rogue_now)
            exp_perr = 1'b1;
        assert (int'(dut.count) <= DEPTH) else begin
            failures++;
            $error("FAIL overflow cyc=%0d count=%0d max=%0d", cyc, dut.count, DEPTH);
        end
        last_req = Mem_Req; last_addr = Mem_Addr;
        last_iv = Instr_Valid; last_ins = Instruction; last_pc = Instr_PC;
        if (Redirect) begin
            stale_n  = pend.size();
            sb.delete();
            exp_addr = Redirect_Addr;
        end
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Redirect = 1'b0; Deq = 1'b0; Mem_Rvalid = 1'b0; Mem_Rdata = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({Mem_Req, Instr_Valid, Proto_Err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {Mem_Req, Instr_Valid, Proto_Err});
        end
        checks++;
        if ({Instruction, Instr_PC} !== 40'h0) begin
            failures++;
            $display("FAIL reset_head got=%h/%h exp=0/0", Instruction, Instr_PC);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        pend.delete(); sb.delete();
        stale_n = 0; exp_addr = '0; exp_perr = 1'b0; cyc = 0; n_req = 0;
        override_en = 1'b0; rogue = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        lat = 2; Deq = 1'b1;
        repeat (5) tick();
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        lat = 2; Deq = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_req !== 4) begin
            failures++;
            $display("FAIL fill_requests got=%0d exp=4", n_req);
        end
        checks++;
        if (last_req !== 1'b0) begin
            failures++;
            $display("FAIL fill_stall got=%b exp=0", last_req);
        end
        checks++;
        if ({Instr_Valid, Instruction, Instr_PC} !== {1'b1, 32'hA000_0000, 8'h00}) begin
            failures++;
            $display("FAIL fill_head got=%b/%h/%h exp=1/a0000000/00", Instr_Valid, Instruction, Instr_PC);
        end
        checks++;
        if (int'(dut.count) !== 4) begin
            failures++;
            $display("FAIL fill_count got=%0d exp=4", dut.count);
        end
    endtask

    task automatic test_stream();
        logic [7:0] prev, nxt;
        logic       have, wrapped;
        int         tail_deq;
        have = 1'b0; wrapped = 1'b0; tail_deq = 0; prev = '0;
        lat = 1; Deq = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (last_iv) begin
                nxt = prev + 8'd1;
                if (have) begin
                    checks++;
                    if (last_pc !== nxt) begin
                        failures++;
                        $display("FAIL stream_gap got=%h exp=%h", last_pc, nxt);
                    end
                    if (prev == 8'hFF && last_pc == 8'h00)
                        wrapped = 1'b1;
                end
                have = 1'b1;
                prev = last_pc;
                if (i >= 200)
                    tail_deq++;
            end
        end
        checks++;
        if (wrapped !== 1'b1) begin
            failures++;
            $display("FAIL stream_wrap got=%b exp=1", wrapped);
        end
        checks++;
        if (tail_deq !== 100) begin
            failures++;
            $display("FAIL stream_rate got=%0d exp=100", tail_deq);
        end
    endtask

    task automatic test_redirect();
        logic found;
        do_reset();
        lat = 2; Deq = 1'b1;
        repeat (6) tick();
        Redirect = 1'b1; Redirect_Addr = 8'h40;
        tick();
        Redirect = 1'b0; Deq = 1'b0;
        tick();
        checks++;
        if ({last_req, last_addr} !== {1'b1, 8'h40}) begin
            failures++;
            $display("FAIL redir_addr got=%b/%h exp=1/40", last_req, last_addr);
        end
        found = Instr_Valid;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = Instr_Valid;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL redir_timeout got=0 exp=1");
        end else if ({Instruction, Instr_PC} !== {32'hA000_0040, 8'h40}) begin
            failures++;
            $display("FAIL redir_head got=%h/%h exp=a0000040/40", Instruction, Instr_PC);
        end
    endtask

    task automatic test_redirect_rvalid_deq();
        do_reset();
        lat = 3; Deq = 1'b0;
        repeat (4) tick();
        Redirect = 1'b1; Redirect_Addr = 8'h80; Deq = 1'b1;
        tick();
        Redirect = 1'b0; Deq = 1'b0;
        checks++;
        if (int'(dut.drop_cnt) !== 2) begin
            failures++;
            $display("FAIL drop_cnt got=%0d exp=2", dut.drop_cnt);
        end
        checks++;
        if (Instr_Valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush got=%b exp=0", Instr_Valid);
        end
        repeat (8) tick();
        checks++;
        if ({Instr_Valid, Instruction, Instr_PC} !== {1'b1, 32'hA000_0080, 8'h80}) begin
            failures++;
            $display("FAIL redir_rv_head got=%b/%h/%h exp=1/a0000080/80", Instr_Valid, Instruction, Instr_PC);
        end
    endtask

    task automatic test_proto();
        do_reset();
        lat = 1; Deq = 1'b0; rogue = 1'b1;
        tick();
        checks++;
        if ({Proto_Err, Instr_Valid} !== 2'b10) begin
            failures++;
            $display("FAIL proto_set got=%b/%b exp=1/0", Proto_Err, Instr_Valid);
        end
        repeat (5) tick();
        do_reset();
    endtask

    task automatic test_bypass();
        do_reset();
        lat = 1; Deq = 1'b1;
        tick();
        override_en = 1'b1; override_data = 32'h1234_5678;
        tick();
`ifdef FETCHQ_BYPASS_EN
        checks++;
        if ({last_iv, last_ins, last_pc} !== {1'b1, 32'h1234_5678, 8'h00}) begin
            failures++;
            $display("FAIL bypass_head got=%b/%h/%h exp=1/12345678/00", last_iv, last_ins, last_pc);
        end
        checks++;
        if (int'(dut.count) !== 0) begin
            failures++;
            $display("FAIL bypass_count got=%0d exp=0", dut.count);
        end
`else
        checks++;
        if (last_iv !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass_head got=%b exp=0", last_iv);
        end
        checks++;
        if (int'(dut.count) !== 1) begin
            failures++;
            $display("FAIL no_bypass_count got=%0d exp=1", dut.count);
        end
`endif
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_redirect_rvalid_deq();
        test_proto();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
